// File: rtl/game_pkg.sv
// Shared definitions for the plane game sequencer: state encoding,
// parameter defaults and a saturating score helper.
package game_pkg;

  // Game sequencer states; the numeric encoding is visible on o_state.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_INVULN = 3'd2,
    ST_WIN    = 3'd3,
    ST_LOSE   = 3'd4
  } state_t;

  // Default parameter values for game_flow_ctrl.
  localparam int DEF_WIN_SCORE        = 10;
  localparam int DEF_START_LIVES      = 3;
  localparam int DEF_FIRE_COOLDOWN    = 12;
  localparam int DEF_INVULN_FRAMES    = 60;
  localparam int DEF_OVER_HOLD_FRAMES = 180;

  // Score increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// 8-bit loadable frame down-counter. A load always wins over a decrement
// in the same cycle; decrements stop at zero. o_zero flags an expired timer.
module frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] r_count;

  // Counter register: load has priority, decrement floors at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: IDLE/PLAY/INVULN/WIN/LOSE flow, score, lives,
// fire cooldown gating and round-start bullet re-arm pulse. All timers
// count frames on the one-clock i_vs_neg tick.
//
// Handshake note: there is no valid/ready flow here. Every input event is
// a one-clock pulse or a level whose rising edge is detected internally,
// and every output pulse (o_shoot_req, o_bullet_rst) is one clock wide,
// registered, and must be consumed by its receiver in that cycle.
//
// Optional feature macro: GAME_AUTOFIRE_EN. When defined, a held
// i_shoot_btn is a continuous fire trigger; otherwise only rising edges fire.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE        = DEF_WIN_SCORE,
  parameter int START_LIVES      = DEF_START_LIVES,
  parameter int FIRE_COOLDOWN    = DEF_FIRE_COOLDOWN,
  parameter int INVULN_FRAMES    = DEF_INVULN_FRAMES,
  parameter int OVER_HOLD_FRAMES = DEF_OVER_HOLD_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_vs_neg,
  input  logic       i_start_btn,
  input  logic       i_shoot_btn,
  input  logic       i_enemy_hit,
  input  logic       i_player_hit,
  output logic [2:0] o_state,
  output logic       o_play_en,
  output logic       o_bullet_rst,
  output logic       o_shoot_req,
  output logic [7:0] o_score,
  output logic [1:0] o_lives,
  output logic       o_flash
);

  localparam logic [7:0] LP_WIN_SCORE   = 8'(WIN_SCORE);
  localparam logic [1:0] LP_START_LIVES = 2'(START_LIVES);
  localparam logic [7:0] LP_COOLDOWN    = 8'(FIRE_COOLDOWN);
  localparam logic [7:0] LP_INVULN      = 8'(INVULN_FRAMES);
  localparam logic [7:0] LP_HOLD        = 8'(OVER_HOLD_FRAMES);

  // Registered state and datapath
  state_t     r_state;
  logic       r_start_d;
  logic       r_shoot_d;
  logic [7:0] r_score;
  logic [1:0] r_lives;
  logic [3:0] r_frame_cnt;
  logic       r_bullet_rst;
  logic       r_shoot_req;
  logic       r_play_en;
  logic       r_flash;

  // Combinational next values and events
  state_t     w_state_nxt;
  logic       w_start_rise;
  logic       w_shoot_rise;
  logic       w_fire_trig;
  logic       w_in_play;
  logic [7:0] w_score_inc;
  logic       w_win_hit;
  logic       w_round_start;
  logic       w_enter_invuln;
  logic       w_enter_over;
  logic       w_shoot_issue;
  logic [7:0] w_score_nxt;
  logic [1:0] w_lives_nxt;
  logic [3:0] w_frame_nxt;
  logic       w_play_en_nxt;
  logic       w_flash_nxt;
  logic       w_cd_load;
  logic [7:0] w_cd_load_val;
  logic       w_cd_zero;
  logic       w_invuln_zero;
  logic       w_hold_zero;

  // Input edge detection against last clock's sample
  assign w_start_rise = i_start_btn & ~r_start_d;
  assign w_shoot_rise = i_shoot_btn & ~r_shoot_d;

`ifdef GAME_AUTOFIRE_EN
  assign w_fire_trig = i_shoot_btn;
`else
  assign w_fire_trig = w_shoot_rise;
`endif

  assign w_in_play   = (r_state == ST_PLAY) || (r_state == ST_INVULN);
  assign w_score_inc = sat_inc8(r_score);
  // An enemy hit that reaches the threshold takes precedence over a player hit.
  assign w_win_hit   = w_in_play && i_enemy_hit && (w_score_inc >= LP_WIN_SCORE);
  assign w_frame_nxt = i_vs_neg ? (r_frame_cnt + 4'd1) : r_frame_cnt;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic and transition events
  always_comb begin
    w_state_nxt    = r_state;
    w_round_start  = 1'b0;
    w_enter_invuln = 1'b0;
    w_enter_over   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_state_nxt   = ST_PLAY;
          w_round_start = 1'b1;
        end
      end
      ST_PLAY: begin
        if (w_win_hit) begin
          w_state_nxt  = ST_WIN;
          w_enter_over = 1'b1;
        end else if (i_player_hit) begin
          if (r_lives <= 2'd1) begin
            w_state_nxt  = ST_LOSE;
            w_enter_over = 1'b1;
          end else begin
            w_state_nxt    = ST_INVULN;
            w_enter_invuln = 1'b1;
          end
        end
      end
      ST_INVULN: begin
        if (w_win_hit) begin
          w_state_nxt  = ST_WIN;
          w_enter_over = 1'b1;
        end else if (w_invuln_zero) begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_WIN, ST_LOSE: begin
        // Edges during the hold are simply lost; nothing is queued.
        if (w_start_rise && w_hold_zero) begin
          w_state_nxt   = ST_PLAY;
          w_round_start = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: next values of score, lives, fire and display outputs
  always_comb begin
    w_score_nxt   = r_score;
    w_lives_nxt   = r_lives;
    w_shoot_issue = 1'b0;
    if (w_round_start) begin
      w_score_nxt = 8'd0;
      w_lives_nxt = LP_START_LIVES;
    end else begin
      if (w_in_play && i_enemy_hit) begin
        w_score_nxt = w_score_inc;
      end
      if ((r_state == ST_PLAY) && i_player_hit && !w_win_hit && (r_lives != 2'd0)) begin
        w_lives_nxt = r_lives - 2'd1;
      end
    end
    if (w_in_play && w_fire_trig && w_cd_zero) begin
      w_shoot_issue = 1'b1;
    end
    w_play_en_nxt = (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_INVULN);
    w_flash_nxt   = (w_state_nxt == ST_INVULN) && w_frame_nxt[3];
  end

  // Datapath and registered output updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_d    <= 1'b0;
      r_shoot_d    <= 1'b0;
      r_score      <= 8'd0;
      r_lives      <= LP_START_LIVES;
      r_frame_cnt  <= 4'd0;
      r_bullet_rst <= 1'b0;
      r_shoot_req  <= 1'b0;
      r_play_en    <= 1'b0;
      r_flash      <= 1'b0;
    end else begin
      r_start_d    <= i_start_btn;
      r_shoot_d    <= i_shoot_btn;
      r_score      <= w_score_nxt;
      r_lives      <= w_lives_nxt;
      r_frame_cnt  <= w_frame_nxt;
      r_bullet_rst <= w_round_start;
      r_shoot_req  <= w_shoot_issue;
      r_play_en    <= w_play_en_nxt;
      r_flash      <= w_flash_nxt;
    end
  end

  // Cooldown clears at round start and reloads on every issued shot.
  assign w_cd_load     = w_round_start | w_shoot_issue;
  assign w_cd_load_val = w_round_start ? 8'd0 : LP_COOLDOWN;

  frame_timer u_cooldown (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cd_load),
    .i_load_val (w_cd_load_val),
    .i_dec      (i_vs_neg),
    .o_zero     (w_cd_zero)
  );

  frame_timer u_invuln (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_enter_invuln),
    .i_load_val (LP_INVULN),
    .i_dec      (i_vs_neg),
    .o_zero     (w_invuln_zero)
  );

  frame_timer u_hold (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_enter_over),
    .i_load_val (LP_HOLD),
    .i_dec      (i_vs_neg),
    .o_zero     (w_hold_zero)
  );

  assign o_state      = r_state;
  assign o_play_en    = r_play_en;
  assign o_bullet_rst = r_bullet_rst;
  assign o_shoot_req  = r_shoot_req;
  assign o_score      = r_score;
  assign o_lives      = r_lives;
  assign o_flash      = r_flash;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl (default parameters).
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_vs_neg;
  logic       i_start_btn;
  logic       i_shoot_btn;
  logic       i_enemy_hit;
  logic       i_player_hit;
  logic [2:0] o_state;
  logic       o_play_en;
  logic       o_bullet_rst;
  logic       o_shoot_req;
  logic [7:0] o_score;
  logic [1:0] o_lives;
  logic       o_flash;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [3:0] frame_model;
  int         shot_cnt;

  // Clock / reset
  always #5 clk = ~clk;

  game_flow_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .i_vs_neg     (i_vs_neg),
    .i_start_btn  (i_start_btn),
    .i_shoot_btn  (i_shoot_btn),
    .i_enemy_hit  (i_enemy_hit),
    .i_player_hit (i_player_hit),
    .o_state      (o_state),
    .o_play_en    (o_play_en),
    .o_bullet_rst (o_bullet_rst),
    .o_shoot_req  (o_shoot_req),
    .o_score      (o_score),
    .o_lives      (o_lives),
    .o_flash      (o_flash)
  );

  // Shot pulse counter, sampled on the inactive edge
  always @(negedge clk) begin
    if (o_shoot_req) shot_cnt++;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_frame();
    i_vs_neg = 1'b1;
    tick();
    frame_model = frame_model + 4'd1;
    i_vs_neg = 1'b0;
    tick();
    tick();
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) vs_frame();
  endtask

  task automatic enemy_pulse();
    i_enemy_hit = 1'b1;
    tick();
    i_enemy_hit = 1'b0;
  endtask

  task automatic player_pulse();
    i_player_hit = 1'b1;
    tick();
    i_player_hit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_vs_neg = 0; i_start_btn = 0; i_shoot_btn = 0; i_enemy_hit = 0; i_player_hit = 0;
    frame_model = 4'd0;
    shot_cnt = 0;
    repeat (3) tick();
    n_tests++;
    if (o_state !== 3'd0) begin $display("FAIL reset_state: got %0d want 0", o_state); n_fail++; end
    n_tests++;
    if (o_score !== 8'd0) begin $display("FAIL reset_score: got %0d want 0", o_score); n_fail++; end
    n_tests++;
    if (o_lives !== 2'd3) begin $display("FAIL reset_lives: got %0d want 3", o_lives); n_fail++; end
    n_tests++;
    if ({o_play_en, o_flash, o_shoot_req, o_bullet_rst} !== 4'b0000) begin
      $display("FAIL reset_pulses: got %b want 0000", {o_play_en, o_flash, o_shoot_req, o_bullet_rst}); n_fail++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_start();
    i_start_btn = 1'b1;
    tick();
    n_tests++;
    if (o_state !== 3'd1) begin $display("FAIL start_state: got %0d want 1", o_state); n_fail++; end
    n_tests++;
    if (o_bullet_rst !== 1'b1) begin $display("FAIL start_bullet_rst: got %b want 1", o_bullet_rst); n_fail++; end
    n_tests++;
    if (o_play_en !== 1'b1) begin $display("FAIL start_play_en: got %b want 1", o_play_en); n_fail++; end
    n_tests++;
    if (o_score !== 8'd0 || o_lives !== 2'd3) begin
      $display("FAIL start_score_lives: got %0d/%0d want 0/3", o_score, o_lives); n_fail++;
    end
    i_start_btn = 1'b0;
    tick();
    n_tests++;
    if (o_bullet_rst !== 1'b0) begin $display("FAIL start_bullet_rst_width: got %b want 0", o_bullet_rst); n_fail++; end
  endtask

  task automatic test_win();
    for (int i = 1; i <= 13; i++) begin
      exp_q.push_back((i > 10) ? 8'd10 : 8'(i));
      enemy_pulse();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (o_score !== exp_v) begin $display("FAIL win_score[%0d]: got %0d want %0d", i, o_score, exp_v); n_fail++; end
    end
    n_tests++;
    if (o_state !== 3'd3) begin $display("FAIL win_state: got %0d want 3", o_state); n_fail++; end
    // Start presses during the hold must be ignored, including one frame early.
    frames(100);
    i_start_btn = 1'b1; tick();
    n_tests++;
    if (o_state !== 3'd3) begin $display("FAIL win_hold_100: got %0d want 3", o_state); n_fail++; end
    i_start_btn = 1'b0; tick();
    frames(79);
    i_start_btn = 1'b1; tick();
    n_tests++;
    if (o_state !== 3'd3) begin $display("FAIL win_hold_179: got %0d want 3", o_state); n_fail++; end
    i_start_btn = 1'b0; tick();
    frames(1);
    i_start_btn = 1'b1; tick();
    n_tests++;
    if (o_state !== 3'd1 || o_score !== 8'd0 || o_bullet_rst !== 1'b1) begin
      $display("FAIL win_restart: got state %0d score %0d brst %b want 1 0 1", o_state, o_score, o_bullet_rst); n_fail++;
    end
    i_start_btn = 1'b0; tick();
  endtask

  task automatic test_lives();
    player_pulse();
    n_tests++;
    if (o_lives !== 2'd2 || o_state !== 3'd2) begin
      $display("FAIL lives_hit1: got lives %0d state %0d want 2 2", o_lives, o_state); n_fail++;
    end
    player_pulse();
    n_tests++;
    if (o_lives !== 2'd2 || o_state !== 3'd2) begin
      $display("FAIL lives_invuln_hit: got lives %0d state %0d want 2 2", o_lives, o_state); n_fail++;
    end
    for (int f = 1; f <= 60; f++) begin
      i_vs_neg = 1'b1;
      tick();
      frame_model = frame_model + 4'd1;
      i_vs_neg = 1'b0;
      n_tests++;
      if (o_flash !== frame_model[3]) begin
        $display("FAIL lives_flash[%0d]: got %b want %b", f, o_flash, frame_model[3]); n_fail++;
      end
      tick();
      n_tests++;
      if (o_state !== ((f == 60) ? 3'd1 : 3'd2)) begin
        $display("FAIL lives_invuln_state[%0d]: got %0d want %0d", f, o_state, (f == 60) ? 1 : 2); n_fail++;
      end
    end
    n_tests++;
    if (o_flash !== 1'b0) begin $display("FAIL lives_flash_play: got %b want 0", o_flash); n_fail++; end
    player_pulse();
    n_tests++;
    if (o_lives !== 2'd1 || o_state !== 3'd2) begin
      $display("FAIL lives_hit2: got lives %0d state %0d want 1 2", o_lives, o_state); n_fail++;
    end
    frames(60);
    n_tests++;
    if (o_state !== 3'd1) begin $display("FAIL lives_back_play: got %0d want 1", o_state); n_fail++; end
    player_pulse();
    n_tests++;
    if (o_lives !== 2'd0 || o_state !== 3'd4 || o_play_en !== 1'b0) begin
      $display("FAIL lives_lose: got lives %0d state %0d play_en %b want 0 4 0", o_lives, o_state, o_play_en); n_fail++;
    end
    frames(180);
    i_start_btn = 1'b1; tick();
    n_tests++;
    if (o_state !== 3'd1 || o_lives !== 2'd3) begin
      $display("FAIL lives_restart: got state %0d lives %0d want 1 3", o_state, o_lives); n_fail++;
    end
    i_start_btn = 1'b0; tick();
  endtask

  task automatic test_fire();
    shot_cnt = 0;
    i_shoot_btn = 1'b1; tick();
    exp_q.push_back(8'd1);
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({7'd0, o_shoot_req} !== exp_v) begin $display("FAIL fire_first: got %b want %0d", o_shoot_req, exp_v); n_fail++; end
    i_shoot_btn = 1'b0; tick();
    n_tests++;
    if (o_shoot_req !== 1'b0) begin $display("FAIL fire_pulse_width: got %b want 0", o_shoot_req); n_fail++; end
    frames(5);
    i_shoot_btn = 1'b1; tick();
    exp_q.push_back(8'd0);
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({7'd0, o_shoot_req} !== exp_v) begin $display("FAIL fire_cooldown_drop: got %b want %0d", o_shoot_req, exp_v); n_fail++; end
    i_shoot_btn = 1'b0; tick();
    frames(7);
    i_shoot_btn = 1'b1; tick();
    exp_q.push_back(8'd1);
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({7'd0, o_shoot_req} !== exp_v) begin $display("FAIL fire_after_12: got %b want %0d", o_shoot_req, exp_v); n_fail++; end
    i_shoot_btn = 1'b0; tick(); tick();
    n_tests++;
    if (shot_cnt !== 2) begin $display("FAIL fire_count: got %0d want 2", shot_cnt); n_fail++; end
  endtask

`ifdef GAME_AUTOFIRE_EN
  task automatic test_autofire();
    frames(12);
    shot_cnt = 0;
    i_shoot_btn = 1'b1; tick();
    for (int f = 1; f <= 36; f++) begin
      i_vs_neg = 1'b1;
      tick();
      frame_model = frame_model + 4'd1;
      i_vs_neg = 1'b0;
      if (f < 36) begin tick(); tick(); end
    end
    i_shoot_btn = 1'b0;
    tick(); tick();
    n_tests++;
    if (shot_cnt !== 3) begin $display("FAIL autofire_count: got %0d want 3", shot_cnt); n_fail++; end
  endtask
`endif

  task automatic test_simultaneous();
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      enemy_pulse();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (o_score !== exp_v) begin $display("FAIL simul_score[%0d]: got %0d want %0d", i, o_score, exp_v); n_fail++; end
    end
    i_enemy_hit = 1'b1; i_player_hit = 1'b1; tick();
    i_enemy_hit = 1'b0; i_player_hit = 1'b0;
    n_tests++;
    if (o_score !== 8'd9 || o_lives !== 2'd2 || o_state !== 3'd2) begin
      $display("FAIL simul_below_win: got score %0d lives %0d state %0d want 9 2 2", o_score, o_lives, o_state); n_fail++;
    end
    frames(60);
    n_tests++;
    if (o_state !== 3'd1) begin $display("FAIL simul_back_play: got %0d want 1", o_state); n_fail++; end
    i_enemy_hit = 1'b1; i_player_hit = 1'b1; tick();
    i_enemy_hit = 1'b0; i_player_hit = 1'b0;
    n_tests++;
    if (o_score !== 8'd10 || o_lives !== 2'd2 || o_state !== 3'd3) begin
      $display("FAIL simul_win: got score %0d lives %0d state %0d want 10 2 3", o_score, o_lives, o_state); n_fail++;
    end
  endtask

  task automatic test_rst_mid();
    frames(180);
    i_start_btn = 1'b1; tick();
    i_start_btn = 1'b0; tick();
    player_pulse();
    n_tests++;
    if (o_state !== 3'd2) begin $display("FAIL rstmid_invuln: got %0d want 2", o_state); n_fail++; end
    frames(10);
    shot_cnt = 0;
    i_shoot_btn = 1'b1; tick();
    n_tests++;
    if (o_shoot_req !== 1'b1) begin $display("FAIL rstmid_shot: got %b want 1", o_shoot_req); n_fail++; end
    rst = 1'b1;
    #1;
    n_tests++;
    if (o_shoot_req !== 1'b0 || o_state !== 3'd0) begin
      $display("FAIL rstmid_async: got shoot %b state %0d want 0 0", o_shoot_req, o_state); n_fail++;
    end
    i_shoot_btn = 1'b0;
    tick();
    n_tests++;
    if (o_state !== 3'd0 || o_lives !== 2'd3 || o_flash !== 1'b0 || o_score !== 8'd0 || o_play_en !== 1'b0) begin
      $display("FAIL rstmid_values: got state %0d lives %0d flash %b score %0d play_en %b want 0 3 0 0 0",
               o_state, o_lives, o_flash, o_score, o_play_en); n_fail++;
    end
    n_tests++;
    if (shot_cnt !== 0) begin $display("FAIL rstmid_no_shot: got %0d want 0", shot_cnt); n_fail++; end
    rst = 1'b0;
    frame_model = 4'd0;
    tick();
  endtask

  initial begin
    test_reset();
    test_start();
    test_win();
    test_lives();
    test_fire();
`ifdef GAME_AUTOFIRE_EN
    test_autofire();
`endif
    test_simultaneous();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
